// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-cycle wide add/subtract controller. A NUM_WORDS*16-bit operation
//   is performed one 16-bit word per clock through a single 16-bit adder.
//   The work starts with the least-significant word. The carry between words
//   is held in a register.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   request carries valid operands
//   in_ready   block can accept a request (IDLE only)
//   op_sub     1: a - b, 0: a + b + cin
//   cin        carry-in for add; ignored for sub
//   a, b       W-bit operands, W = 16*NUM_WORDS
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        W-bit result
//   cout       final carry; for sub, 1 = no borrow
//   ovf        two's-complement signed overflow
//   zero       sum == 0

// 16-bit adder slice shared by every word of the wide operation.
module SixteenBitAdder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {16'd0, ci};
endmodule

module wide_add_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op_sub,
  input  logic                      cin,
  input  logic [16*NUM_WORDS-1:0]   a,
  input  logic [16*NUM_WORDS-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [16*NUM_WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      zero
);
  localparam int W    = 16 * NUM_WORDS;
  localparam int IDXW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operands shift right by one word per RUN cycle.
  // Word [15:0] is therefore always the word currently being added.
  // On the last cycle, bit 15 is the operand sign bit.
  logic [W-1:0]    a_reg, b_reg;
  // Partial result. Each new word is shifted in at the top, so after
  // NUM_WORDS cycles the words sit at their proper positions.
  logic [W-1:0]    res_reg;
  logic [W-1:0]    res_next;
  logic            carry_reg;
  logic [IDXW-1:0] idx_reg;
  logic            last_word;

  logic [W-1:0]    sum_reg;
  logic            cout_reg, ovf_reg, zero_reg;

  logic [15:0]     add_s;
  logic            add_co;

  SixteenBitAdder u_adder (
    .a  (a_reg[15:0]),
    .b  (b_reg[15:0]),
    .ci (carry_reg),
    .s  (add_s),
    .co (add_co)
  );

  assign last_word = (idx_reg == IDXW'(NUM_WORDS - 1));
  assign res_next  = {add_s, res_reg[W-1:16]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_word) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            // Subtraction is a + ~b + 1. The +1 enters as the initial carry.
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? 1'b1 : cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 16;
          b_reg     <= b_reg >> 16;
          res_reg   <= res_next;
          carry_reg <= add_co;
          idx_reg   <= idx_reg + 1'b1;
          if (last_word) begin
            // The visible result updates only here, on entry to DONE.
            sum_reg  <= res_next;
            cout_reg <= add_co;
            ovf_reg  <= (a_reg[15] == b_reg[15]) && (add_s[15] != a_reg[15]);
            zero_reg <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide-operand adder/subtractor controller built around one shared SixteenBitAdder instance.
- Splits NUM_WORDS*16-bit operands into 16-bit words, LS word first, one word per clock.
- Chains carry between words through a carry register.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output) in the ALU datapath; gives 64-bit add/sub without a 64-bit ripple chain.

Parameters:
- NUM_WORDS, 4, number of 16-bit words per operand (legal 2..8); operand width W = 16*NUM_WORDS.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request carries valid operands
- in_ready  output  1  block can accept a request
- op_sub  input  1  1 = a - b, 0 = a + b + cin
- cin  input  1  carry-in for add; ignored when op_sub=1
- a  input  W  operand A
- b  input  W  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result
- cout  output  1  final carry; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset: one clock, synchronous, active-high; port names clk and rst.
- rst=1 at an edge gives state IDLE and clears all result and operand registers:
  - in_ready=1 after reset; out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - Word index = 0, carry register = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: latch a; latch b (stored inverted when op_sub=1); carry register = op_sub ? 1 : cin; word index = 0; go to RUN.
- RUN:
  - in_ready=0; in_valid ignored.
  - Each cycle the adder sees A word[idx], B' word[idx] and the carry register.
  - At each edge: write the adder Sum into result word[idx]; carry register <= adder Cout; idx <= idx+1.
  - After the edge that writes word NUM_WORDS-1, go to DONE.
  - In that same edge register the output flags:
    - cout = final adder Cout.
    - ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]).
    - zero computed on the complete result.
- DONE:
  - out_valid=1; sum, cout, ovf, zero held stable.
  - On out_ready=1 at an edge: out_valid<=0, go to IDLE.
  - out_ready low holds DONE indefinitely.
- Latency: request accepted at edge T; out_valid first high after edge T+NUM_WORDS (4 cycles at default).
- Throughput: one result per NUM_WORDS+2 cycles minimum; in_ready is not asserted in DONE, so no overlap.
- Result words not yet written in RUN are undefined internally. sum, cout, ovf, zero change only on entry to DONE, on rst, or remain at their last values; consumers sample them only while out_valid=1.
- Width rules:
  - All arithmetic is modulo 2^W.
  - Carry out of the MS word never wraps into the LS word.
  - Subtraction is a + ~b + 1.
- Simultaneous events:
  - rst overrides everything, including in_valid in IDLE and out_ready in DONE.
  - Reset mid-RUN aborts the operation; no out_valid is produced for it.
- Single SixteenBitAdder instance only; no second adder and no W-bit combinational add.

Test Plan:
- Carry chain: add, a=0x0000_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x0001_0000_0000_0000, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- Full wrap: add, a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0.
- Sub/borrow: op_sub=1, a=0, b=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0; then a=5, b=3 -> sum=2, cout=1.
- Signed overflow: add, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0; sub a=0x8000_0000_0000_0000 - 1 -> ovf=1.
- Backpressure: out_ready=0 for 6 cycles with in_valid=1 and a new operand -> outputs stable, in_ready=0, new request not taken; out_ready=1 -> IDLE next cycle, new request accepted the cycle after.
- Reset mid-op: rst=1 on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; fresh request 1+2 -> sum=3 with normal 4-cycle latency.
